// File: rtl/spi_master_pkg.sv
// Shared SPI constants: frame geometry, command encodings and the master FSM states.
// The SPI slave imports the same command constants.
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CTRL,
        SEND,
        TURN,
        RECV,
        GAPW
    } state_t;

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake between the local controller and spi_master.
// "master" is the controller side, "slave" is the spi_master side.
interface spi_master_if;
    import spi_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [FRAME_BITS-1:0] cmd_data;
    logic [DATA_BITS-1:0]  rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, rd_data, rd_valid, busy, done
    );

endinterface

// File: rtl/spi_shift_reg.sv
// Generic left-shifting register with parallel load; MSB is the serial output,
// sin enters at the LSB.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= din;
        else if (shift) q <= {q[W-2:0], sin};
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator clocked by clk itself: control bit + 10 command bits MSB-first on MOSI,
// optional turnaround and 8-bit MISO capture for read-data commands.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus,
    output logic         SS_n,
    output logic         MOSI,
    input  logic         MISO
);

    localparam int unsigned GAP_EFF   = (GAP < 1) ? 1 : GAP;
    localparam logic [3:0]  SEND_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0]  RECV_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  TURN_LAST = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP_EFF - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic                  is_rd;
    logic                  cmd_ready;
    logic                  busy;
    logic                  done;
    logic                  rd_valid;
    logic [DATA_BITS-1:0]  rd_data;
    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0]  rx_q;
    logic                  accept;
    logic                  tx_shift;
    logic                  rx_shift;
    logic                  unused_bits;

    assign accept   = (state == IDLE) && bus.cmd_valid && cmd_ready;
    assign tx_shift = (state == CTRL) || ((state == SEND) && (cnt != '0));
    // MISO is sampled on the edge that opens each RECV cycle, so the first
    // sample lands at the end of the last turnaround (or last SEND) cycle.
    assign rx_shift = ((state == TURN) && (cnt == '0))
                   || ((state == SEND) && (cnt == '0) && is_rd && (TURNAROUND == 0))
                   || ((state == RECV) && (cnt != '0));

    spi_shift_reg #(.W(FRAME_BITS)) u_tx (
        .clk(clk), .rst(rst), .load(accept), .din(bus.cmd_data),
        .shift(tx_shift), .sin(1'b0), .q(tx_q)
    );

    spi_shift_reg #(.W(DATA_BITS)) u_rx (
        .clk(clk), .rst(rst), .load(1'b0), .din('0),
        .shift(rx_shift), .sin(MISO), .q(rx_q)
    );

    assign unused_bits = ^{tx_q[FRAME_BITS-2:0], rx_q[DATA_BITS-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_rd     <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        state     <= CTRL;
                        is_rd     <= (bus.cmd_data[FRAME_BITS-1 -: 2] == CMD_RD_DATA);
                        SS_n      <= 1'b0;
                        MOSI      <= bus.cmd_data[FRAME_BITS-1];
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CTRL: begin
                    state <= SEND;
                    cnt   <= SEND_LAST;
                    MOSI  <= tx_q[FRAME_BITS-1];
                end
                SEND: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - 4'd1;
                        MOSI <= tx_q[FRAME_BITS-1];
                    end else if (is_rd && (TURNAROUND > 0)) begin
                        state <= TURN;
                        cnt   <= TURN_LAST;
                        MOSI  <= 1'b0;
                    end else if (is_rd) begin
                        state <= RECV;
                        cnt   <= RECV_LAST;
                        MOSI  <= 1'b0;
                    end else begin
                        state <= GAPW;
                        cnt   <= GAP_LAST;
                        SS_n  <= 1'b1;
                        MOSI  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                TURN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RECV;
                        cnt   <= RECV_LAST;
                    end
                end
                RECV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            rd_data  <= {rx_q[DATA_BITS-2:0], MISO};
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        state <= GAPW;
                        cnt   <= GAP_LAST;
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                GAPW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_data;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: per-cycle SS_n/MOSI/done/rd_valid traces against
// the frame timing, plus back-to-back, mid-frame poke and reset-abort scenarios.
module tb_spi_master;

    localparam int TA = 2;
    localparam int GP = 1;

    logic clk;
    logic rst;
    logic SS_n;
    logic MOSI;
    logic MISO;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd;

    logic [31:0] bss, bmo, bdn, bss_e, bmo_e, bdn_e;

    spi_master_if bus();

    spi_master #(.TURNAROUND(TA), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Value on MOSI in cycle T+k of a frame accepted at edge T.
    function automatic logic exp_mosi(input logic [9:0] c, input int k);
        if (k == 1)               return c[9];
        else if (k >= 2 && k <= 11) return c[11-k];
        else                      return 1'b0;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".rdy"}, bus.cmd_ready, 1);
    endtask

    task automatic idle(input int n, input string tag);
        int nd = 0, nr = 0, nl = 0;
        repeat (n) begin
            tick();
            nd += int'(bus.done);
            nr += int'(bus.rd_valid);
            nl += int'(!SS_n);
        end
        check({tag, ".done"}, nd, 0);
        check({tag, ".rdv"},  nr, 0);
        check({tag, ".sslow"}, nl, 0);
    endtask

    task automatic run_frame(input logic [9:0] cmd, input logic [7:0] rx, input int poke, input string tag);
        bit rd;
        int nlow;
        logic [31:0] ss_t, mo_t, dn_t, rv_t, ss_e, mo_e, dn_e, rv_e;
        logic [7:0] rcap;
        rd   = (cmd[9:8] == 2'b11);
        nlow = rd ? 19 + TA : 11;
        ss_t = '0; mo_t = '0; dn_t = '0; rv_t = '0;
        ss_e = '0; mo_e = '0; dn_e = '0; rv_e = '0;
        rcap = 'x;
        wait_ready(tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = cmd;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= nlow + 1; k++) begin
            ss_t[k-1] = SS_n;
            mo_t[k-1] = MOSI;
            dn_t[k-1] = bus.done;
            rv_t[k-1] = bus.rd_valid;
            if (bus.rd_valid === 1'b1) rcap = bus.rd_data;
            ss_e[k-1] = (k > nlow);
            mo_e[k-1] = exp_mosi(cmd, k);
            dn_e[k-1] = (k == nlow + 1);
            rv_e[k-1] = rd && (k == nlow);
            if (k == poke) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_data  = 10'h3FF;
                check({tag, ".poke_ready"}, bus.cmd_ready, 0);
            end
            if (poke > 0 && k == poke + 1) bus.cmd_valid = 1'b0;
            // Slave presents bit 7 in the last turnaround cycle, bit 0 seven cycles later.
            MISO = (rd && k >= 11 + TA && k <= 18 + TA) ? rx[18 + TA - k] : 1'b0;
            tick();
        end
        MISO = 1'b0;
        check({tag, ".ss"},   ss_t, ss_e);
        check({tag, ".mosi"}, mo_t, mo_e);
        check({tag, ".done"}, dn_t, dn_e);
        check({tag, ".rdv"},  rv_t, rv_e);
        if (rd) begin
            check({tag, ".rdata"}, rcap, rx);
            exp_rd = rx;
        end
        check({tag, ".hold"}, bus.rd_data, exp_rd);
    endtask

    initial begin
        rst           = 1'b1;
        MISO          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        exp_rd        = 8'h00;

        // Reset state
        tick();
        check("rst.ss_n",  SS_n, 1);
        check("rst.mosi",  MOSI, 0);
        check("rst.ready", bus.cmd_ready, 0);
        check("rst.busy",  bus.busy, 0);
        check("rst.done",  bus.done, 0);
        check("rst.rdv",   bus.rd_valid, 0);
        check("rst.rdata", bus.rd_data, 8'h00);
        rst = 1'b0;
        tick();
        check("post_rst.ready", bus.cmd_ready, 1);
        idle(20, "idle20");
        check("idle20.mosi", MOSI, 0);

        // Write-addr 0A5: ctrl 0, then 0,0,1,0,1,0,0,1,0,1
        run_frame(10'h0A5, 8'h00, 0, "wa");
        // Read-data with slave replying C3: SS_n low 21 cycles, rd_valid T+21, done T+22
        run_frame(10'h300, 8'hC3, 0, "rd");
        // Read-addr must not touch rd_data
        run_frame(10'h23C, 8'h00, 0, "ra");

        // Back-to-back with cmd_valid held: second frame accepted in the IDLE cycle after GAPW
        wait_ready("b2b");
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h155;
        tick();
        bus.cmd_data  = 10'h0FF;
        for (int k = 1; k <= 26; k++) begin
            bss[k-1]   = SS_n;
            bmo[k-1]   = MOSI;
            bdn[k-1]   = bus.done;
            bss_e[k-1] = !((k >= 1 && k <= 11) || (k >= 14 && k <= 24));
            bmo_e[k-1] = (k <= 13) ? exp_mosi(10'h155, k) : exp_mosi(10'h0FF, k - 13);
            bdn_e[k-1] = (k == 12) || (k == 25);
            if (k == 14) bus.cmd_valid = 1'b0;
            tick();
        end
        check("b2b.ss",   bss[25:0], bss_e[25:0]);
        check("b2b.mosi", bmo[25:0], bmo_e[25:0]);
        check("b2b.done", bdn[25:0], bdn_e[25:0]);
        idle(15, "b2b_idle");

        // cmd_valid pulse in the middle of a write-data frame is ignored
        run_frame(10'h16B, 8'h00, 5, "poke");
        idle(15, "poke_idle");

        // Reset during SEND of a read-data frame, while bit 5 is on MOSI
        wait_ready("abort");
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 10'h3A5;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (5) tick();
        check("abort.bit5", MOSI, 1);
        check("abort.ss_pre", SS_n, 0);
        rst = 1'b1;
        tick();
        check("abort.ss_n",  SS_n, 1);
        check("abort.mosi",  MOSI, 0);
        check("abort.busy",  bus.busy, 0);
        check("abort.ready", bus.cmd_ready, 0);
        rst    = 1'b0;
        exp_rd = 8'h00;
        MISO   = 1'b1;
        idle(30, "abort_idle");
        check("abort.rdata", bus.rd_data, 8'h00);
        MISO = 1'b0;

        // Frames after the abort are serialised normally
        run_frame(10'h1C3, 8'h00, 0, "wd_after");
        run_frame(10'h35A, 8'h5A, 0, "rd_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
